// File: rtl/mreg_pipe.sv
// mreg_pipe: N-way input-select register pipeline with per-stage valid bits,
// a global advance enable and a flush.
// Optional feature macro: MREG_PIPE_COUNT_EN. When defined, count is a
// registered number of valid stages; otherwise count is tied to zero.
module mreg_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1,
    parameter int NSEL  = 2,
    parameter int SELW  = 1,
    parameter int CNTW  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [SELW-1:0]       sel,
    input  logic [NSEL*WIDTH-1:0] d,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic [CNTW-1:0]       count
);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] m;

    // Input select; a select beyond the populated inputs yields zero data
    always_comb begin
        m = '0;
        for (int k = 0; k < NSEL; k++) begin
            if (sel == SELW'(k)) begin
                m = d[k*WIDTH +: WIDTH];
            end
        end
    end

    // Stage valid bits: reset and flush clear, en shifts in the new valid
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else if (en) begin
            v[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                v[i] <= v[i-1];
            end
        end
    end

    // Stage data: only valid beats move forward so bubbles never toggle data
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
            end
        end else if (!flush && en) begin
            if (in_valid) begin
                data[0] <= m;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (v[i-1]) begin
                    data[i] <= data[i-1];
                end
            end
        end
    end

    assign q       = data[DEPTH-1];
    assign q_valid = v[DEPTH-1];

`ifdef MREG_PIPE_COUNT_EN
    logic [CNTW-1:0] count_r;

    // Valid-stage counter tracking the beat entering and the beat leaving
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (flush) begin
            count_r <= '0;
        end else if (en) begin
            count_r <= count_r + CNTW'(in_valid) - CNTW'(v[DEPTH-1]);
        end
    end

    assign count = count_r;
`else
    assign count = '0;
`endif

endmodule

// File: tb/tb_mreg_pipe.sv
// tb_mreg_pipe: directed checks of mreg_pipe with WIDTH=4, DEPTH=3, NSEL=3.
// Count expectations follow whether MREG_PIPE_COUNT_EN is defined.
module tb_mreg_pipe;

    localparam int WIDTH = 4;
    localparam int DEPTH = 3;
    localparam int NSEL  = 3;
    localparam int SELW  = 2;
    localparam int CNTW  = 2;

    logic                  clk;
    logic                  reset;
    logic                  en;
    logic                  flush;
    logic                  in_valid;
    logic [SELW-1:0]       sel;
    logic [NSEL*WIDTH-1:0] d;
    logic [WIDTH-1:0]      q;
    logic                  q_valid;
    logic [CNTW-1:0]       count;

    int checks = 0;
    int errors = 0;

    mreg_pipe #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .NSEL (NSEL),
        .SELW (SELW),
        .CNTW (CNTW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .flush   (flush),
        .in_valid(in_valid),
        .sel     (sel),
        .d       (d),
        .q       (q),
        .q_valid (q_valid),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, take one posedge, then settle past it
    task automatic applyStimulus(input logic r, input logic e, input logic f,
                                 input logic iv, input logic [SELW-1:0] s,
                                 input logic [NSEL*WIDTH-1:0] dv);
        reset    = r;
        en       = e;
        flush    = f;
        in_valid = iv;
        sel      = s;
        d        = dv;
        @(posedge clk);
        #1;
    endtask

    // Compare q, q_valid and count against hand-computed values
    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] eq,
                               input logic ev, input int ec);
        logic [CNTW-1:0] exp_cnt;
`ifdef MREG_PIPE_COUNT_EN
        exp_cnt = CNTW'(ec);
`else
        exp_cnt = '0;
`endif
        checks++;
        assert (q === eq) else begin
            errors++;
            $error("[TB] FAIL %s.q: got %h expected %h", tag, q, eq);
        end
        checks++;
        assert (q_valid === ev) else begin
            errors++;
            $error("[TB] FAIL %s.q_valid: got %b expected %b", tag, q_valid, ev);
        end
        checks++;
        assert (count === exp_cnt) else begin
            errors++;
            $error("[TB] FAIL %s.count: got %0d expected %0d", tag, count, exp_cnt);
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b0;
        sel = '0; d = '0;

        // Reset with garbage on every input
        applyStimulus(1, 1, 0, 1, 2'd2, 12'hABC);
        applyStimulus(1, 1, 1, 1, 2'd1, 12'h5E7);
        checkOutput("reset", 4'h0, 1'b0, 0);

        // Latency and select: A on input 2, exits after three edges
        applyStimulus(0, 1, 0, 1, 2'd2, {4'hA, 4'h1, 4'h2});
        checkOutput("lat_e0", 4'h0, 1'b0, 1);
        applyStimulus(0, 1, 0, 0, 2'd0, 12'h777);
        checkOutput("lat_e1", 4'h0, 1'b0, 1);
        applyStimulus(0, 1, 0, 0, 2'd0, 12'h777);
        checkOutput("lat_e2", 4'hA, 1'b1, 1);
        applyStimulus(0, 1, 0, 0, 2'd0, 12'h777);
        checkOutput("lat_e3", 4'hA, 1'b0, 0);

        // Stall: beat 5 sits in stage 1 while en is low for five cycles
        applyStimulus(0, 1, 0, 1, 2'd0, {4'h9, 4'h9, 4'h5});
        applyStimulus(0, 1, 0, 0, 2'd0, 12'h999);
        checkOutput("stall_pre", 4'hA, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 1, 2'd1, 12'hEEE);
            checkOutput("stall_hold", 4'hA, 1'b0, 1);
        end
        applyStimulus(0, 1, 0, 0, 2'd0, 12'h000);
        checkOutput("stall_out", 4'h5, 1'b1, 1);
        applyStimulus(0, 1, 0, 0, 2'd0, 12'h000);
        checkOutput("stall_gone", 4'h5, 1'b0, 0);

        // Bubble data hold: A, bubble carrying F, B
        applyStimulus(0, 1, 0, 1, 2'd1, {4'h0, 4'hA, 4'h0});
        checkOutput("bub_e0", 4'h5, 1'b0, 1);
        applyStimulus(0, 1, 0, 0, 2'd1, 12'hFFF);
        checkOutput("bub_e1", 4'h5, 1'b0, 1);
        applyStimulus(0, 1, 0, 1, 2'd1, {4'h0, 4'hB, 4'h0});
        checkOutput("bub_e2", 4'hA, 1'b1, 2);
        applyStimulus(0, 1, 0, 0, 2'd1, 12'hFFF);
        checkOutput("bub_e3", 4'hA, 1'b0, 1);
        applyStimulus(0, 1, 0, 0, 2'd1, 12'hFFF);
        checkOutput("bub_e4", 4'hB, 1'b1, 1);
        applyStimulus(0, 1, 0, 0, 2'd1, 12'hFFF);
        checkOutput("bub_e5", 4'hB, 1'b0, 0);

        // Flush collision on a full pipe
        applyStimulus(0, 1, 0, 1, 2'd0, 12'h00C);
        applyStimulus(0, 1, 0, 1, 2'd0, 12'h00D);
        applyStimulus(0, 1, 0, 1, 2'd0, 12'h00E);
        checkOutput("full", 4'hC, 1'b1, 3);
        applyStimulus(0, 1, 1, 1, 2'd0, 12'h007);
        checkOutput("flush", 4'hC, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 2'd0, 12'h007);
            checkOutput("post_flush", 4'hC, 1'b0, 0);
        end

        // Out-of-range select delivers a valid zero beat
        applyStimulus(0, 1, 0, 1, 2'd3, 12'hFFF);
        applyStimulus(0, 1, 0, 0, 2'd0, 12'hFFF);
        applyStimulus(0, 1, 0, 0, 2'd0, 12'hFFF);
        checkOutput("sel_oor", 4'h0, 1'b1, 1);

        // Reset mid-stream drops the beat in flight
        applyStimulus(0, 1, 0, 1, 2'd2, {4'h6, 4'h0, 4'h0});
        applyStimulus(0, 1, 0, 0, 2'd0, 12'h000);
        applyStimulus(1, 1, 0, 0, 2'd0, 12'h000);
        checkOutput("mid_reset", 4'h0, 1'b0, 0);
        applyStimulus(0, 1, 0, 0, 2'd0, 12'h000);
        checkOutput("mid_reset_after", 4'h0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mreg_pipe.md
# mreg_pipe

Parametrised successor to the single-stage mux/enable registers. It is an N-way input-select register pipeline of configurable width and depth. Each stage carries a valid bit and supports a global advance enable and a flush. It sits between a datapath mux and downstream consumers wherever a multi-cycle, stallable, flushable registered path is needed.

## Interface
Parameters:
- WIDTH, default 1: data width per input and per stage.
- DEPTH, default 1: number of pipeline stages. Legal range is 1 to 16.
- NSEL, default 2: number of data inputs. Legal range is 2 to 16.
- SELW, default 1: width of sel. The caller must give a value with 2^SELW ≥ NSEL.
- CNTW, default 1: width of count. The caller must give a value with 2^CNTW > DEPTH.

Ports (one synchronous clock `clk`; reset `reset` is synchronous and active-high):
- clk, input, 1: clock; all state updates on the posedge.
- reset, input, 1: synchronous, active-high reset.
- en, input, 1: advance enable; the pipeline shifts only when en=1.
- flush, input, 1: invalidates every stage.
- in_valid, input, 1: the selected input is valid this cycle.
- sel, input, SELW: input select.
- d, input, NSEL*WIDTH: packed data inputs; input k occupies d[k*WIDTH +: WIDTH].
- q, output, WIDTH: data of the last stage.
- q_valid, output, 1: valid bit of the last stage.
- count, output, CNTW: number of valid stages (see Configuration).

## Operation
- State per stage i (i = 0 to DEPTH-1): data[i] (WIDTH bits) and v[i] (1 bit).
- Mux: m = d[sel*WIDTH +: WIDTH] when sel < NSEL. When sel ≥ NSEL, m = 0.
- Priority order each posedge: reset > flush > en.
- reset=1: all v[i] ← 0 and all data[i] ← 0.
- flush=1 (with reset=0): all v[i] ← 0, including any incoming beat; data[i] hold; en is ignored.
- en=1 (with reset=0, flush=0):
  - v[0] ← in_valid; v[i] ← v[i-1].
  - data[0] ← m only if in_valid=1, otherwise it holds.
  - data[i] ← data[i-1] only if v[i-1]=1, otherwise it holds. Bubbles do not toggle data.
- en=0 (with reset=0, flush=0): all state holds. in_valid, sel and d are ignored.
- Outputs: q = data[DEPTH-1] and q_valid = v[DEPTH-1], driven directly from flops with no combinational path from inputs.
- DEPTH=1 degenerates to a single mux-enable register whose valid bit tracks in_valid.
- Inputs that are X are outside the contract. Verification constrains en, flush, reset and sel to be known.

## Timing
- Latency: a beat accepted on an edge with en=1 reaches q/q_valid after exactly DEPTH edges with en=1, counting the accepting edge. Cycles with en=0 add delay 1:1.
- Throughput: one beat per en=1 cycle. There is no backpressure output; the upstream must honour en.
- Reset values: q=0, q_valid=0, count=0 on the cycle after the reset edge.
- flush takes effect on the next edge. q_valid is 0 in the following cycle and q keeps its old value.
- Reset or flush mid-stream: beats in flight are lost and are never reissued.
- Simultaneous en=1, flush=1 and in_valid=1: the incoming beat is dropped.

## Configuration
- Macro: MREG_PIPE_COUNT_EN.
- Defined: count is a registered popcount of v[], updated on the same edge as v[] and ranging 0 to DEPTH. It is incremented, decremented or held based on the valid entering and leaving, not recomputed combinationally. It goes to 0 on reset or flush.
- Undefined: count is tied to 0 and no counter logic exists. All other behaviour is identical.

## Test plan
- Reset: with WIDTH=4, DEPTH=3, drive reset=1 for 2 cycles with garbage on inputs → q=0, q_valid=0, count=0.
- Latency and select: with WIDTH=4, DEPTH=3, NSEL=3, hold en=1 and inject in_valid=1 with sel=2 and d input 2 = 4'hA at cycle 0 → q=4'hA and q_valid=1 at cycle 3 only; count reads 1, 1, 1 and then 0 after the beat exits.
- Stall: with the same beat in stage 1, drop en to 0 for 5 cycles → q, q_valid and count are frozen; the beat emerges exactly 5 cycles late.
- Bubble data hold: inject A (valid), then a bubble with d=4'hF, then B (valid) → q shows A, then A with q_valid=0, then B; 4'hF never appears on q.
- Flush collision: with a full pipe (count=3), assert en=1, flush=1 and in_valid=1 in one cycle → next cycle q_valid=0, count=0, and q holds its prior value; no beat appears over the next 3 cycles.
- Out-of-range sel and macro off: with NSEL=3, SELW=2, sel=3 and in_valid=1 → the beat emerges with q=0 and q_valid=1. Building without MREG_PIPE_COUNT_EN gives count=0 throughout the full test set while all other checks still pass.
